// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction encoder with buffered output FIFO
// Scatters decoded fields into a 32-bit word; illegal requests become NOPs flagged with out_err.
module instr_encoder #(
   parameter int DEPTH = 4,
   parameter int ERR_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_fmt,
   input  logic [6:0]               in_opcode,
   input  logic [2:0]               in_funct3,
   input  logic [6:0]               in_funct7,
   input  logic [4:0]               in_rd,
   input  logic [4:0]               in_rs1,
   input  logic [4:0]               in_rs2,
   input  logic [31:0]              in_imm,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_instr,
   output logic                     out_err,
   output logic [ERR_W-1:0]         err_count,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [31:0]   enc;
   logic          enc_err;
   logic          accept;
   logic          push;
   logic          pop;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [31:0]   instr_mem [DEPTH];
   logic          err_mem   [DEPTH];

   // Range checks: the sign-extension bits above each field must all match.
   logic fits_12, fits_13, fits_21;
   assign fits_12 = (&in_imm[31:11]) || (~|in_imm[31:11]);
   assign fits_13 = (&in_imm[31:12]) || (~|in_imm[31:12]);
   assign fits_21 = (&in_imm[31:20]) || (~|in_imm[31:20]);

   always_comb begin
      enc     = NOP;
      enc_err = 1'b0;
      case (in_fmt)
         3'd0: enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         3'd1: begin
            enc     = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            enc_err = !fits_12;
         end
         3'd2: begin
            enc     = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            enc_err = !fits_12;
         end
         3'd3: begin
            enc     = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:1], in_imm[11], in_opcode};
            enc_err = !fits_13 || in_imm[0];
         end
         3'd4: begin
            enc     = {in_imm[31:12], in_rd, in_opcode};
            enc_err = |in_imm[11:0];
         end
         3'd5: begin
            enc     = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            enc_err = !fits_21 || in_imm[0];
         end
         default: enc_err = 1'b1;
      endcase
      if (enc_err) enc = NOP;
   end

   assign in_ready  = (count < FULL);
   assign out_valid = (count != '0);
   assign accept    = in_valid && in_ready;
   assign push      = accept && !flush;
   assign pop       = out_valid && out_ready && !flush;
   assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;
   assign out_err   = out_valid ? err_mem[rd_ptr] : 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         err_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_mem[i] <= '0;
            err_mem[i]   <= 1'b0;
         end
      end else begin
         // Errors are counted on acceptance, even when a flush discards the entry.
         if (accept && enc_err && (err_count != '1))
            err_count <= err_count + ERR_W'(1);
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) begin
               instr_mem[wr_ptr] <= enc;
               err_mem[wr_ptr]   <= enc_err;
               wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop)
               rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
               count <= count + (AW+1)'(1);
            else if (pop && !push)
               count <= count - (AW+1)'(1);
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
// Hand-computed RV32I words, FIFO backpressure, flush and asynchronous reset.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_fmt = '0;
   logic [6:0]  in_opcode = '0;
   logic [2:0]  in_funct3 = '0;
   logic [6:0]  in_funct7 = '0;
   logic [4:0]  in_rd = '0;
   logic [4:0]  in_rs1 = '0;
   logic [4:0]  in_rs2 = '0;
   logic [31:0] in_imm = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic        out_err;
   logic [15:0] err_count;
   logic [2:0]  count;

   int tests = 0;
   int fails = 0;
   int exp_ec = 0;
   int accepted;

   instr_encoder #(.DEPTH(4), .ERR_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
      .err_count(err_count), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] imm);
      in_fmt = fmt; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
      in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic single(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                         input logic [31:0] exp_i, input logic exp_e);
      set_req(fmt, op, f3, f7, rd, rs1, rs2, imm);
      chk({tag, "_idle"}, out_valid, 0);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      if (exp_e) exp_ec++;
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_instr"}, out_instr, exp_i);
      chk({tag, "_err"}, out_err, exp_e);
      chk({tag, "_errcnt"}, err_count, exp_ec);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_drained"}, count, 0);
   endtask

   initial begin
      tick();
      tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_instr", out_instr, 0);
      chk("rst_err", out_err, 0);
      chk("rst_errcnt", err_count, 0);
      rst_n = 1'b1;
      #1;
      chk("rst_ready", in_ready, 1);

      single("i6",     3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd6,         32'h00600113, 1'b0);
      single("i4",     3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd4,         32'h00400113, 1'b0);
      single("u_ok",   3'd4, 7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h12345000,  32'h12345037, 1'b0);
      single("u_bad",  3'd4, 7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h12345001,  32'h00000013, 1'b1);
      single("b8",     3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,         32'h00208463, 1'b0);
      single("b7",     3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd7,         32'h00000013, 1'b1);
      single("i2048",  3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd2048,      32'h00000013, 1'b1);
      single("im2048", 3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, -32'sd2048,    32'h80000113, 1'b0);
      single("b4094",  3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd4094,      32'h7E208FE3, 1'b0);
      single("r_sub",  3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'hDEADBEEF,  32'h402081B3, 1'b0);
      single("s_m4",   3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, -32'sd4,       32'hFE20AE23, 1'b0);
      single("j2048",  3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048,      32'h001000EF, 1'b0);
      single("j_big",  3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1048576,   32'h00000013, 1'b1);
      single("fmt6",   3'd6, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd0,         32'h00000013, 1'b1);

      // Backpressure: six offered, only four fit.
      accepted = 0;
      set_req(3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd0);
      for (int i = 0; i < 6; i++) begin
         in_imm = i;
         in_valid = 1'b1;
         if (in_ready) accepted++;
         tick();
      end
      in_valid = 1'b0;
      chk("bp_accepted", accepted, 4);
      chk("bp_count", count, 4);
      chk("bp_ready", in_ready, 0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("bp_order", out_instr, 32'h00000113 | (i << 20));
         tick();
      end
      out_ready = 1'b0;
      chk("bp_empty", out_valid, 0);

      // Simultaneous push and pop at count=2.
      for (int i = 0; i < 2; i++) begin
         in_imm = 10 + i;
         in_valid = 1'b1;
         tick();
      end
      in_imm = 12;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("pp_count", count, 2);
      chk("pp_head", out_instr, 32'h00B00113);
      out_ready = 1'b1;
      tick();
      chk("pp_tail", out_instr, 32'h00C00113);
      tick();
      out_ready = 1'b0;

      // Flush at count=3 with a concurrent erroneous accept.
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         tick();
      end
      chk("fl_pre", count, 3);
      set_req(3'd7, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      exp_ec++;
      chk("fl_count", count, 0);
      chk("fl_valid", out_valid, 0);
      chk("fl_errcnt", err_count, exp_ec);

      // Asynchronous reset between edges with two entries queued.
      set_req(3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd5);
      in_valid = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      chk("ar_pre", count, 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", out_valid, 0);
      chk("ar_count", count, 0);
      chk("ar_errcnt", err_count, 0);
      #3;
      rst_n = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
